// File: rtl/ota_decimator.sv
// Comparator-bitstream decimator: synchronises the raw comparator output and emits
// a ones count per 2^WIN_LOG2-cycle window over a valid/ready port.
module ota_decimator #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cmp_in,
  output logic [WIN_LOG2:0]   sample,
  output logic                valid,
  input  logic                ready,
  output logic                ovr,
  output logic                busy
);

  // valid/ready: a sample is consumed on any rising edge where valid && ready;
  // sample is held stable while valid=1 and ready=0, and valid only falls on a
  // consume (or rst).

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WIN_LOG2:0]   acc_q, acc_d;
  logic [WIN_LOG2:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                win_end;
  logic [WIN_LOG2:0]   result;
  logic                cmp_s;

  assign cmp_s  = sync2_q;
  assign result = acc_q + {{WIN_LOG2{1'b0}}, cmp_s};

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    win_end  = 1'b0;

    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        acc_d  = '0;
        if (en) state_d = ACCUM;
      end
      ACCUM: begin
        if (!en) begin
          // Abort the partial window; a pending sample is left untouched.
          state_d = IDLE;
          wcnt_d  = '0;
          acc_d   = '0;
        end else begin
          wcnt_d = wcnt_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
          if (wcnt_q == {WIN_LOG2{1'b1}}) begin
            win_end = 1'b1;
            acc_d   = '0;
          end else begin
            acc_d = result;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (win_end) begin
      if (!valid_q || ready) begin
        sample_d = result;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      wcnt_q   <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= cmp_in;
      sync2_q  <= sync1_q;
      wcnt_q   <= wcnt_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample = sample_q;
  assign valid  = valid_q;
  assign ovr    = ovr_q;
  assign busy   = (state_q == ACCUM);

endmodule

// File: tb/tb_ota_decimator.sv
// Bench for ota_decimator (16-cycle windows): directed scenarios with literal
// expectations plus a randomized run, all checked each cycle against a window model.
module tb_ota_decimator;
  localparam int W = 4;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, en, cmp_in, ready;
  logic [W:0] sample;
  logic       valid, ovr, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the comparator input as seen two edges ago, plus window bookkeeping.
  int m_hist[$];
  bit m_accum;
  int m_pos, m_cnt;
  bit m_valid, m_ovr;
  int m_sample;
  bit toggle_mode = 1'b0;

  always #5 clk = ~clk;

  ota_decimator #(.WIN_LOG2(W)) dut (
    .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in),
    .sample(sample), .valid(valid), .ready(ready), .ovr(ovr), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  used;
    bit  done;
    int  res;
    done = 1'b0;
    res  = 0;
    if (rst) begin
      m_hist   = '{0, 0};
      m_accum  = 1'b0;
      m_pos    = 0;
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_sample = 0;
    end else begin
      used = m_hist[0];
      m_hist.push_back(int'(cmp_in));
      void'(m_hist.pop_front());
      if (m_accum) begin
        if (en) begin
          m_cnt += used;
          m_pos++;
          if (m_pos == N) begin
            done  = 1'b1;
            res   = m_cnt;
            m_cnt = 0;
            m_pos = 0;
          end
        end else begin
          m_accum = 1'b0;
          m_cnt   = 0;
          m_pos   = 0;
        end
      end else if (en) begin
        m_accum = 1'b1;
      end
      if (done) begin
        if (!m_valid || ready) begin
          m_sample = res;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", int'(busy), int'(m_accum));
    chk("valid", int'(valid), int'(m_valid));
    chk("ovr", int'(ovr), int'(m_ovr));
    if (m_valid) chk("sample", int'(sample), m_sample);
    if (toggle_mode) cmp_in = ~cmp_in;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until valid is seen high; returns the number of steps taken.
  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      cyc++;
      if (valid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_valid: got timeout after %0d cycles, expected valid", budget);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int held;
    rst = 1'b1; en = 1'b0; cmp_in = 1'b0; ready = 1'b0;
    m_hist = '{0, 0};
    run(2);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // All ones: full-scale sample every window.
    cmp_in = 1'b1; ready = 1'b1;
    run(3);
    en = 1'b1;
    step();
    chk("start_busy", int'(busy), 1);
    wait_valid(40, cyc);
    chk("start_latency", cyc, N);
    chk("ones_sample", int'(sample), 16);
    wait_valid(40, cyc);
    chk("ones_spacing", cyc, N);
    chk("ones_sample2", int'(sample), 16);

    // All zeros.
    do_reset();
    en = 1'b0; cmp_in = 1'b0; run(3);
    en = 1'b1;
    wait_valid(40, cyc);
    chk("zeros_sample", int'(sample), 0);

    // Alternating input: half scale in every window.
    do_reset();
    en = 1'b0; toggle_mode = 1'b1; run(3);
    en = 1'b1;
    wait_valid(40, cyc);
    chk("alt_sample", int'(sample), 8);
    wait_valid(40, cyc);
    chk("alt_sample2", int'(sample), 8);
    toggle_mode = 1'b0;

    // Overrun: consumer stalls across two window ends.
    do_reset();
    cmp_in = 1'b1; ready = 1'b0; en = 1'b0; run(3);
    en = 1'b1;
    run(40);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_sample", int'(sample), 16);
    chk("ovr_flag", int'(ovr), 1);
    ready = 1'b1; step(); ready = 1'b0;
    chk("ovr_accept", int'(valid), 0);
    wait_valid(40, cyc);
    chk("ovr_reload_gap", cyc, 8);

    // Back-to-back: ready high exactly on a window end while valid is set.
    cmp_in = 1'b0;
    run(15);
    ready = 1'b1; step();
    chk("b2b_valid", int'(valid), 1);
    chk("b2b_sample", int'(sample), 2);
    chk("b2b_ovr", int'(ovr), 1);

    // Abort mid-window with a pending sample.
    cmp_in = 1'b1; ready = 1'b0;
    wait_valid(40, cyc);
    held = int'(sample);
    run(7);
    en = 1'b0; step();
    chk("abort_busy", int'(busy), 0);
    chk("abort_keep", int'(sample), held);
    en = 1'b1; step();
    chk("abort_keep2", int'(sample), held);
    ready = 1'b1; step(); ready = 1'b0;
    wait_valid(40, cyc);
    chk("abort_fresh_gap", cyc, N - 1);
    chk("abort_fresh_sample", int'(sample), 16);

    // Reset mid-window with valid and ovr set.
    run(5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_ovr", int'(ovr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sample", int'(sample), 0);
    wait_valid(40, cyc);
    chk("resume_gap", cyc, N + 1);
    chk("resume_sample", int'(sample), 15);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cmp_in = 1'($urandom_range(0, 1));
      ready  = ($urandom_range(0, 3) == 0);
      en     = ($urandom_range(0, 99) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
